// File: rtl/wb_lsu.sv
// wb_lsu: Wishbone B4 classic load/store unit (one bus cycle per request).
//   Decodes RISC-V funct3 into width/sign, builds byte selects, lane-shifts
//   store data, aligns and extends load data, and bounds each bus cycle with
//   a timeout.
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   req_i/we_i/funct3_i/addr_i/wdata_i   request from the datapath
//   rdata_o/done_o/fault_o/cause_o       completion (valid while done_o=1)
//   stall_o                     combinational datapath stall
//   wbm_*                       Wishbone master side
module wb_lsu #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [1:0]        cause_o,
    output logic              stall_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [XLEN-1:0]   wbm_dat_o,
    input  logic [XLEN-1:0]   wbm_dat_i,
    output logic              wbm_we_o,
    output logic [XLEN/8-1:0] wbm_sel_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam int SW  = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] C_MISAL = 2'b00;
    localparam logic [1:0] C_BUSERR = 2'b01;
    localparam logic [1:0] C_TMO   = 2'b10;
    localparam logic [1:0] C_ILL   = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [OFF-1:0]  off_q, off_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [XLEN-1:0] dat_q, dat_d;
    logic [NB-1:0]   sel_q, sel_d;
    logic            we_q, we_d, cyc_q, cyc_d;

    // request decode
    logic [OFF-1:0]  off;
    logic            illegal, misal;
    logic [NB-1:0]   bm, sel;
    logic [XLEN-1:0] dm, sdat;

    assign off = addr_i[OFF-1:0];

    always_comb begin
        illegal = 1'b0;
        case (funct3_i)
            3'b011, 3'b110: illegal = (XLEN != 64);
            3'b111:         illegal = 1'b1;
            default:        illegal = 1'b0;
        endcase
        // stores have no sign variant
        if (we_i && funct3_i[2]) illegal = 1'b1;
    end

    always_comb begin
        misal = 1'b0;
        bm    = '0;
        case (funct3_i[1:0])
            2'd0: begin misal = 1'b0;          bm = NB'(8'h01); end
            2'd1: begin misal = addr_i[0];     bm = NB'(8'h03); end
            2'd2: begin misal = |addr_i[1:0];  bm = NB'(8'h0F); end
            default: begin misal = |addr_i[2:0]; bm = NB'(8'hFF); end
        endcase
    end

    // byte mask expanded to bits so unused store lanes go out as zero
    always_comb begin
        dm = '0;
        for (int i = 0; i < NB; i++) dm[8*i +: 8] = {8{bm[i]}};
    end

    assign sel  = bm << off;
    assign sdat = (wdata_i & dm) << {off, 3'b000};

    // load alignment: shift the addressed lane down, then push the access
    // to the top and back so one shift pair does truncate + extend
    logic [XLEN-1:0]        ld_sh, ld_shl, ld_zx, ld_val;
    logic signed [XLEN-1:0] ld_sx;
    logic [SW-1:0]          lsh;

    always_comb begin
        case (f3_q[1:0])
            2'd0:    lsh = SW'(XLEN - 8);
            2'd1:    lsh = SW'(XLEN - 16);
            2'd2:    lsh = SW'(XLEN - 32);
            default: lsh = '0;
        endcase
        ld_sh  = wbm_dat_i >> {off_q, 3'b000};
        ld_shl = ld_sh << lsh;
        ld_zx  = ld_shl >> lsh;
        ld_sx  = $signed(ld_shl) >>> lsh;
        ld_val = f3_q[2] ? ld_zx : $unsigned(ld_sx);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        fault_d = fault_q;
        cause_d = cause_q;
        rdata_d = rdata_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                fault_d = 1'b0;
                cause_d = 2'b00;
                rdata_d = '0;
                if (req_i) begin
                    if (illegal) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                        cause_d = C_ILL;
                    end else if (misal) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                        cause_d = C_MISAL;
                    end else begin
                        state_d = S_BUS;
                        adr_d   = {addr_i[AW-1:OFF], {OFF{1'b0}}};
                        sel_d   = sel;
                        we_d    = we_i;
                        dat_d   = sdat;
                        cyc_d   = 1'b1;
                        f3_d    = funct3_i;
                        off_d   = off;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (wbm_err_i || wbm_ack_i || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end
                // err wins over a simultaneous ack
                if (wbm_err_i) begin
                    fault_d = 1'b1;
                    cause_d = C_BUSERR;
                    rdata_d = '0;
                end else if (wbm_ack_i) begin
                    fault_d = 1'b0;
                    rdata_d = ld_val;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    cause_d = C_TMO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            rdata_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
        end
    end

    assign done_o    = (state_q == S_DONE);
    assign fault_o   = fault_q;
    assign cause_o   = cause_q;
    assign rdata_o   = rdata_q;
    assign stall_o   = ((state_q == S_IDLE) && req_i) || (state_q == S_BUS);
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
endmodule

// File: tb/tb_wb_lsu.sv
// Scoreboard bench: dut 0 is XLEN=32, dut 1 is XLEN=64. Stimulus pushes the
// expected completion; the monitor pops and compares on each done_o.
module tb_wb_lsu;
    typedef struct {
        int          d;
        logic        fault;
        logic [1:0]  cause;
        logic        chk_rd;
        logic [63:0] rdata;
        int          ccnt;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] dat;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req, we, done_a, fault_a, stall_a, cyc_a, stb_a, wwe_a, ack, err;
    logic [2:0]  f3 [2];
    logic [31:0] addr [2];
    logic [63:0] wdata [2];
    logic [63:0] sdat [2];
    logic [1:0]  cause_a [2];
    logic [31:0] adr_a [2];
    logic [63:0] rd_a [2], dat_a [2];
    logic [7:0]  sel_a [2];
    logic [31:0] rd32, dat32;
    logic [3:0]  sel32;
    logic [63:0] rd64, dat64;
    logic [7:0]  sel64;

    int s_mode [2];  // 0 ack, 1 err, 2 ack+err, 3 silent
    int s_wait [2];
    int wcnt [2];

    exp_t sbq [$];
    int n_tot = 0, n_pass = 0;

    wb_lsu #(.XLEN(32), .AW(32), .TIMEOUT(16)) u32 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .funct3_i(f3[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0][31:0]), .rdata_o(rd32), .done_o(done_a[0]),
        .fault_o(fault_a[0]), .cause_o(cause_a[0]), .stall_o(stall_a[0]),
        .wbm_adr_o(adr_a[0]), .wbm_dat_o(dat32), .wbm_dat_i(sdat[0][31:0]),
        .wbm_we_o(wwe_a[0]), .wbm_sel_o(sel32), .wbm_cyc_o(cyc_a[0]), .wbm_stb_o(stb_a[0]),
        .wbm_ack_i(ack[0]), .wbm_err_i(err[0]));

    wb_lsu #(.XLEN(64), .AW(32), .TIMEOUT(16)) u64 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .funct3_i(f3[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rd64), .done_o(done_a[1]),
        .fault_o(fault_a[1]), .cause_o(cause_a[1]), .stall_o(stall_a[1]),
        .wbm_adr_o(adr_a[1]), .wbm_dat_o(dat64), .wbm_dat_i(sdat[1]),
        .wbm_we_o(wwe_a[1]), .wbm_sel_o(sel64), .wbm_cyc_o(cyc_a[1]), .wbm_stb_o(stb_a[1]),
        .wbm_ack_i(ack[1]), .wbm_err_i(err[1]));

    assign rd_a[0]  = {32'h0, rd32};
    assign dat_a[0] = {32'h0, dat32};
    assign sel_a[0] = {4'h0, sel32};
    assign rd_a[1]  = rd64;
    assign dat_a[1] = dat64;
    assign sel_a[1] = sel64;

    // slave: responds combinationally once s_wait cycles of cyc have passed
    always @(posedge clk)
        for (int i = 0; i < 2; i++) wcnt[i] <= cyc_a[i] ? wcnt[i] + 1 : 0;

    assign ack[0] = cyc_a[0] & stb_a[0] & (wcnt[0] == s_wait[0]) & (s_mode[0] == 0 || s_mode[0] == 2);
    assign ack[1] = cyc_a[1] & stb_a[1] & (wcnt[1] == s_wait[1]) & (s_mode[1] == 0 || s_mode[1] == 2);
    assign err[0] = cyc_a[0] & stb_a[0] & (wcnt[0] == s_wait[0]) & (s_mode[0] == 1 || s_mode[0] == 2);
    assign err[1] = cyc_a[1] & stb_a[1] & (wcnt[1] == s_wait[1]) & (s_mode[1] == 1 || s_mode[1] == 2);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t mkx(input logic fault, input logic [1:0] cause, input logic chk_rd,
                                 input logic [63:0] rdata, input int ccnt, input logic [31:0] adr,
                                 input logic [7:0] sel, input logic [63:0] dat, input logic w);
        exp_t e;
        e.d = 0; e.fault = fault; e.cause = cause; e.chk_rd = chk_rd; e.rdata = rdata;
        e.ccnt = ccnt; e.adr = adr; e.sel = sel; e.dat = dat; e.we = w;
        return e;
    endfunction

    // monitor
    int          mc [2];
    logic        stab [2];
    logic [31:0] c_adr [2];
    logic [7:0]  c_sel [2];
    logic [63:0] c_dat [2];
    logic        c_we [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mc[i] = 0; stab[i] = 1'b1;
            end else begin
                if (cyc_a[i]) begin
                    if (mc[i] == 0) begin
                        c_adr[i] = adr_a[i]; c_sel[i] = sel_a[i]; c_dat[i] = dat_a[i]; c_we[i] = wwe_a[i];
                    end else if (c_adr[i] !== adr_a[i] || c_sel[i] !== sel_a[i] ||
                                 c_dat[i] !== dat_a[i] || c_we[i] !== wwe_a[i]) begin
                        stab[i] = 1'b0;
                    end
                    if (stb_a[i] !== 1'b1) stab[i] = 1'b0;
                    mc[i]++;
                end
                if (done_a[i]) begin
                    if (sbq.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_done dut%0d: done_o=1 with no request outstanding", i);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("dut_id", 64'(i), 64'(e.d));
                        chk("fault", fault_a[i], e.fault);
                        if (e.fault) chk("cause", cause_a[i], e.cause);
                        if (e.chk_rd) chk("rdata", rd_a[i], e.rdata);
                        chk("cyc_cycles", 64'(mc[i]), 64'(e.ccnt));
                        chk("stall_in_done", stall_a[i], 1'b0);
                        if (e.ccnt > 0) begin
                            chk("adr", c_adr[i], e.adr);
                            chk("sel", c_sel[i], e.sel);
                            chk("dat", c_dat[i], e.dat);
                            chk("we", c_we[i], e.we);
                            chk("bus_stable", stab[i], 1'b1);
                        end
                    end
                    mc[i] = 0; stab[i] = 1'b1;
                end
            end
        end
    end

    task automatic run(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [63:0] wd, input int mode, input int waits, input logic [63:0] sd,
                       input exp_t e, input int lat, input bit drop);
        int k;
        bit seen;
        s_mode[d] = mode; s_wait[d] = waits; sdat[d] = sd;
        e.d = d;
        sbq.push_back(e);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wdata[d] = wd;
        #1 chk("stall_on_req", stall_a[d], 1'b1);
        seen = 0; k = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (drop && k == 2) req[d] = 1'b0;
            if (done_a[d]) seen = 1;
        end
        req[d] = 1'b0;
        chk("latency", seen ? 64'(k) : 64'hFFFF, 64'(lat));
    endtask

    initial begin
        rst = 1'b1;
        req = '0; we = '0;
        for (int i = 0; i < 2; i++) begin
            f3[i] = '0; addr[i] = '0; wdata[i] = '0; sdat[i] = '0; s_mode[i] = 3; s_wait[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ctrl", {done_a[i], fault_a[i], cause_a[i], cyc_a[i], stb_a[i], wwe_a[i], stall_a[i], sel_a[i]}, 64'h0);
            chk("rst_rdata", rd_a[i], 64'h0);
            chk("rst_adr_dat", {adr_a[i], dat_a[i][31:0]} | dat_a[i], 64'h0);
        end
        rst = 1'b0;

        // XLEN=32
        run(0, 1, 3'b000, 32'h1003, 64'h1234_56AB, 0, 0, 64'h0,
            mkx(0, 2'b00, 0, 64'h0, 1, 32'h1000, 8'h08, 64'hAB00_0000, 1), 2, 0);
        run(0, 0, 3'b001, 32'h2002, 64'h0, 0, 0, 64'h8001_1234,
            mkx(0, 2'b00, 1, 64'hFFFF_8001, 1, 32'h2000, 8'h0C, 64'h0, 0), 2, 0);
        run(0, 0, 3'b101, 32'h2002, 64'h0, 0, 0, 64'h8001_1234,
            mkx(0, 2'b00, 1, 64'h0000_8001, 1, 32'h2000, 8'h0C, 64'h0, 0), 2, 0);
        run(0, 0, 3'b000, 32'h2001, 64'h0, 0, 1, 64'h0000_8500,
            mkx(0, 2'b00, 1, 64'hFFFF_FF85, 2, 32'h2000, 8'h02, 64'h0, 0), 3, 0);
        run(0, 1, 3'b010, 32'h0003, 64'h5, 0, 0, 64'h0,
            mkx(1, 2'b00, 0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 0), 1, 0);
        run(0, 1, 3'b100, 32'h0001, 64'h5, 0, 0, 64'h0,
            mkx(1, 2'b11, 0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 0), 1, 0);
        run(0, 0, 3'b011, 32'h0000, 64'h0, 0, 0, 64'h0,
            mkx(1, 2'b11, 0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 0), 1, 0);
        // silent slave, req dropped mid-transfer: still times out
        run(0, 0, 3'b010, 32'h0010, 64'h0, 3, 0, 64'h0,
            mkx(1, 2'b10, 0, 64'h0, 16, 32'h0010, 8'h0F, 64'h0, 0), 17, 1);
        run(0, 0, 3'b010, 32'h0020, 64'h0, 2, 0, 64'hFFFF_FFFF,
            mkx(1, 2'b01, 1, 64'h0, 1, 32'h0020, 8'h0F, 64'h0, 0), 2, 0);
        run(0, 1, 3'b001, 32'h0026, 64'hBEEF, 1, 1, 64'h0,
            mkx(1, 2'b01, 1, 64'h0, 2, 32'h0024, 8'h0C, 64'hBEEF_0000, 1), 3, 0);

        // reset during the 2nd BUS cycle
        s_mode[0] = 3;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; f3[0] = 3'b010; addr[0] = 32'h30;
        @(negedge clk);
        @(negedge clk);
        chk("rst_bus_cyc_before", cyc_a[0], 1'b1);
        rst = 1'b1; req[0] = 1'b0;
        @(posedge clk);
        #1 chk("rst_bus_cyc_stb", {cyc_a[0], stb_a[0], done_a[0]}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run(0, 1, 3'b010, 32'h0040, 64'hDEAD_BEEF, 0, 0, 64'h0,
            mkx(0, 2'b00, 0, 64'h0, 1, 32'h0040, 8'h0F, 64'hDEAD_BEEF, 1), 2, 0);

        // XLEN=64
        run(1, 0, 3'b011, 32'h0008, 64'h0, 0, 2, 64'h0123_4567_89AB_CDEF,
            mkx(0, 2'b00, 1, 64'h0123_4567_89AB_CDEF, 3, 32'h0008, 8'hFF, 64'h0, 0), 4, 0);
        run(1, 0, 3'b010, 32'h0004, 64'h0, 0, 0, 64'h8765_4321_0000_0000,
            mkx(0, 2'b00, 1, 64'hFFFF_FFFF_8765_4321, 1, 32'h0000, 8'hF0, 64'h0, 0), 2, 0);
        run(1, 0, 3'b110, 32'h0004, 64'h0, 0, 0, 64'h8765_4321_0000_0000,
            mkx(0, 2'b00, 1, 64'h0000_0000_8765_4321, 1, 32'h0000, 8'hF0, 64'h0, 0), 2, 0);
        run(1, 1, 3'b001, 32'h0016, 64'hFFFF_BEEF, 0, 0, 64'h0,
            mkx(0, 2'b00, 0, 64'h0, 1, 32'h0010, 8'hC0, 64'hBEEF_0000_0000_0000, 1), 2, 0);
        run(1, 0, 3'b111, 32'h0000, 64'h0, 0, 0, 64'h0,
            mkx(1, 2'b11, 0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 0), 1, 0);
        run(1, 1, 3'b011, 32'h0004, 64'h1, 0, 0, 64'h0,
            mkx(1, 2'b00, 0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 0), 1, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
